// File: rtl/qpl_allocator.sv
// rtl/qpl_allocator.sv - first-fit power-of-two block allocator over an occupancy bitmap
module qpl_allocator #(
    parameter int BITMAP = 256,
    localparam int BLOCK_W = $clog2(BITMAP)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_alloc_vld,
    output logic               o_alloc_rdy,
    input  logic [BLOCK_W:0]   i_alloc_size,
    output logic               o_resp_vld,
    input  logic               i_resp_rdy,
    output logic               o_resp_ok,
    output logic [BLOCK_W-1:0] o_resp_addr,
    output logic [BLOCK_W:0]   o_resp_size,
    input  logic               i_dealloc_vld,
    input  logic [BLOCK_W-1:0] i_dealloc_addr,
    input  logic [BLOCK_W:0]   i_dealloc_size,
    output logic [BITMAP-1:0]  o_bitmap,
    output logic               o_busy
);

    localparam int EXT_W = BLOCK_W + 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]         state;
    logic [BLOCK_W:0]   rsize;
    // Cursor kept in block units (c*rsize) so no multiplier is needed.
    logic [BLOCK_W:0]   cur_addr;
    logic [BITMAP-1:0]  bitmap;
    logic [BITMAP-1:0]  cand_mask;
    logic [BITMAP-1:0]  dealloc_mask;
    logic [EXT_W-1:0]   cand_end;
    logic [EXT_W-1:0]   dealloc_end;
    logic               cand_free;
    logic               cand_last;
    logic               commit;
    logic               size_bad;
    logic               accept;

    function automatic logic [BLOCK_W:0] round_pow2(input logic [BLOCK_W:0] s);
        logic [BLOCK_W:0] r;
        r = '0;
        for (int k = BLOCK_W; k >= 0; k--) begin
            if (((BLOCK_W+1)'(1) << k) >= s) r = (BLOCK_W+1)'(1) << k;
        end
        return r;
    endfunction

    assign cand_end    = EXT_W'(cur_addr) + EXT_W'(rsize);
    assign dealloc_end = EXT_W'(i_dealloc_addr) + EXT_W'(i_dealloc_size);

    always_comb begin
        cand_mask    = '0;
        dealloc_mask = '0;
        for (int i = 0; i < BITMAP; i++) begin
            cand_mask[i]    = (EXT_W'(i) >= EXT_W'(cur_addr)) && (EXT_W'(i) < cand_end);
            dealloc_mask[i] = i_dealloc_vld && (EXT_W'(i) >= EXT_W'(i_dealloc_addr))
                              && (EXT_W'(i) < dealloc_end);
        end
    end

    assign cand_free   = (bitmap & cand_mask) == '0;
    assign cand_last   = cand_end == EXT_W'(BITMAP);
    assign commit      = (state == ST_SEARCH) && cand_free;
    assign size_bad    = (i_alloc_size == '0) || (EXT_W'(i_alloc_size) > EXT_W'(BITMAP));
    assign o_alloc_rdy = (state == ST_IDLE) && !i_rst;
    assign accept      = i_alloc_vld && o_alloc_rdy;
    assign o_resp_vld  = (state == ST_RESP);
    assign o_busy      = (state != ST_IDLE);
    assign o_bitmap    = bitmap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            bitmap      <= '0;
            rsize       <= '0;
            cur_addr    <= '0;
            o_resp_ok   <= 1'b0;
            o_resp_addr <= '0;
            o_resp_size <= '0;
        end else begin
            // Clear first, then set: a commit overlapping a same-edge dealloc survives.
            bitmap <= (bitmap & ~dealloc_mask) | (commit ? cand_mask : '0);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsize    <= round_pow2(i_alloc_size);
                        cur_addr <= '0;
                        if (size_bad) begin
                            o_resp_ok   <= 1'b0;
                            o_resp_addr <= '0;
                            o_resp_size <= '0;
                            state       <= ST_RESP;
                        end else begin
                            state <= ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (cand_free) begin
                        o_resp_ok   <= 1'b1;
                        o_resp_addr <= cur_addr[BLOCK_W-1:0];
                        o_resp_size <= rsize;
                        state       <= ST_RESP;
                    end else if (cand_last) begin
                        o_resp_ok   <= 1'b0;
                        o_resp_addr <= '0;
                        o_resp_size <= '0;
                        state       <= ST_RESP;
                    end else begin
                        cur_addr <= cur_addr + rsize;
                    end
                end
                ST_RESP: begin
                    if (i_resp_rdy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/qpl_allocator.md
Name: qpl_allocator

Overview:
- Allocation-side counterpart of the deallocation/compression path in the QuickPageLite block manager.
- Accepts allocation requests (size in blocks) over a valid/ready handshake and rounds each size up to a power of two.
- Performs a sequential first-fit search for a free, naturally aligned slot in an internal occupancy bitmap, marks it used, and returns the address on a valid/ready response channel.
- Also accepts dealloc commands with the same addr/size encoding the compressor consumes, which clear bitmap bits.

Parameters:
- BITMAP, 256, number of managed blocks; power of two, >= 4.
- BLOCK_W (localparam), $clog2(BITMAP), block address width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_alloc_vld  in  1  allocation request valid.
- o_alloc_rdy  out  1  request accepted when i_alloc_vld && o_alloc_rdy.
- i_alloc_size  in  BLOCK_W+1  requested blocks, not zero-indexed.
- o_resp_vld  out  1  response valid.
- i_resp_rdy  in  1  response consumed when o_resp_vld && i_resp_rdy.
- o_resp_ok  out  1  1 = slot granted, 0 = failure.
- o_resp_addr  out  BLOCK_W  granted start block, 0 on failure.
- o_resp_size  out  BLOCK_W+1  granted (rounded) size, 0 on failure.
- i_dealloc_vld  in  1  dealloc command valid; always accepted.
- i_dealloc_addr  in  BLOCK_W  first block to free.
- i_dealloc_size  in  BLOCK_W+1  blocks to free, not zero-indexed.
- o_bitmap  out  BITMAP  registered occupancy; bit i = 1 means block i is used.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - bitmap = 0 (all free), state = IDLE.
  - o_resp_vld = 0, o_resp_ok = 0, o_resp_addr = 0, o_resp_size = 0.
  - o_alloc_rdy = 0 while i_rst is high, 1 in the first cycle after.
- FSM states: IDLE, SEARCH, RESP. o_alloc_rdy = (state == IDLE) && !i_rst.
- IDLE:
  - On accept, latch rsize = smallest power of two >= i_alloc_size.
  - If i_alloc_size == 0 or i_alloc_size > BITMAP: go to RESP with ok = 0, addr = 0, size = 0.
  - Otherwise: clear cursor c and go to SEARCH.
- SEARCH (one candidate per cycle):
  - Candidate addr = c*rsize.
  - If bitmap[addr +: rsize] is all zero: set those bits, go to RESP with ok = 1, addr, size = rsize.
  - Else if c == BITMAP/rsize - 1: go to RESP with ok = 0.
  - Else c <= c + 1.
  - Cursor width BLOCK_W+1; no wrap, the search ends at the last aligned slot.
- RESP:
  - Hold o_resp_* stable until i_resp_rdy, then go to IDLE and drop o_resp_vld in the same edge.
  - The next request can be accepted in the following cycle.
- Latency, with the handshake in cycle T:
  - Invalid size: o_resp_vld in T+1.
  - Slot found at cursor j: o_resp_vld in T+2+j; o_bitmap shows the set bits in that same cycle.
  - Exhausted: o_resp_vld in T+1+BITMAP/rsize.
- Dealloc (any state, same-edge update):
  - Clears bitmap bits [addr, addr+size); bits at index >= BITMAP are ignored.
  - size == 0 is a no-op.
  - Freeing already-free bits is harmless and no error is flagged.
  - Dealloc on the commit edge: clear is applied first, then the commit set, so commit wins on overlap.
  - Dealloc during SEARCH does not rewind the cursor; slots already rejected are not revisited.
- Reset mid-SEARCH or mid-RESP: the request is aborted, no bits stay committed, no response is issued.
- i_alloc_size is ignored outside the accept cycle.

Test Plan (BITMAP=16):
- Reset, then alloc size 3 -> o_resp_vld at T+2, ok=1, addr=0, size=4, o_bitmap=16'h000F.
- Then alloc size 1 -> addr=4 at T+6 (cursor 4), o_bitmap=16'h001F.
- Alloc size 0, and separately size 17 -> ok=0, addr=0, size=0, o_resp_vld at T+1, bitmap unchanged.
- Bitmap 16'h0101, alloc size 16 -> ok=0 at T+2. Then dealloc addr 0 size 16 -> bitmap 0; alloc size 16 -> ok=1, addr=0.
- Hold i_resp_rdy=0 for 5 cycles -> response fields stable, o_alloc_rdy=0. Assert rdy -> IDLE next cycle.
- Dealloc addr 8 size 4 on the commit edge of an alloc landing at addr 8 size 4 -> bits 8..11 end up set, ok=1.
- Assert i_rst during SEARCH -> o_bitmap=0, o_resp_vld never rises, o_alloc_rdy=1 after reset.
